// File: rtl/sigma_delta_dac_pkg.sv
// Shared sigma-delta constants: DAC defaults, dither LFSR seed/taps and ADC-side settings.
// Imported by sigma_delta_dac, sd_lfsr16 and the companion ADC blocks.
package sigma_delta_dac_pkg;

    localparam int SD_DATA_W_DEFAULT = 8;
    localparam int SD_OSR_DEFAULT    = 64;

    // Galois form of x^16+x^14+x^13+x^11+1, shifting right
    localparam logic [15:0] SD_LFSR_SEED = 16'hACE1;
    localparam logic [15:0] SD_LFSR_TAPS = 16'hB400;

    localparam int SD_ADC_CIC_ORDER     = 3;
    localparam int SD_ADC_DECIM_DEFAULT = 64;
    localparam int SD_ADC_OUT_W_DEFAULT = 16;

    typedef enum logic {
        HOLD_EMPTY = 1'b0,
        HOLD_FULL  = 1'b1
    } hold_state_e;

endpackage

// File: rtl/sigma_delta_dac_lfsr.sv
// sd_lfsr16: free-running 16-bit Galois LFSR; bit 0 is the dither carry-in of the DAC.
module sd_lfsr16
    import sigma_delta_dac_pkg::*;
(
    input  logic clk,
    input  logic rst,
    output logic dither
);

    logic [15:0] state_reg;
    logic [15:0] state_next;

    // Every bit shifts down one place and takes the tap feedback from the outgoing bit 0
    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_step
            if (gi == 15) begin : g_top
                assign state_next[gi] = SD_LFSR_TAPS[gi] & state_reg[0];
            end else begin : g_mid
                assign state_next[gi] = state_reg[gi+1] ^ (SD_LFSR_TAPS[gi] & state_reg[0]);
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= SD_LFSR_SEED;
        end else begin
            state_reg <= state_next;
        end
    end

    assign dither = state_reg[0];

endmodule

// File: rtl/sigma_delta_dac.sv
// First-order delta-sigma DAC with a one-entry sample holding register, frame-aligned updates.
// Optional dither: define SIGMA_DELTA_DAC_DITHER_EN to add an LFSR carry-in to the modulator.
module sigma_delta_dac
    import sigma_delta_dac_pkg::*;
#(
    parameter int DATA_W = SD_DATA_W_DEFAULT,
    parameter int OSR    = SD_OSR_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] sampleIn,
    input  logic              sampleValid,
    output logic              sampleReady,
    output logic              dacOut,
    output logic              frameStrobe,
    output logic              underrun
);

    localparam int               CNT_W    = $clog2(OSR);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OSR - 1);

    logic [CNT_W-1:0]  cnt_reg;
    hold_state_e       hold_state_reg;
    logic [DATA_W-1:0] hold_reg;
    logic [DATA_W-1:0] active_reg;
    logic [DATA_W-1:0] acc_reg;
    logic              dac_reg;

    logic              frame_last;
    logic              hold_empty;
    logic              accept;
    logic              dither_bit;
    logic [DATA_W:0]   sum_next;

    assign frame_last  = (cnt_reg == CNT_LAST);
    assign hold_empty  = (hold_state_reg == HOLD_EMPTY);
    assign sampleReady = hold_empty && !rst;
    assign accept      = sampleValid && sampleReady;
    assign frameStrobe = frame_last && !rst;
    assign underrun    = frameStrobe && hold_empty;
    assign dacOut      = dac_reg;

`ifdef SIGMA_DELTA_DAC_DITHER_EN
    sd_lfsr16 u_lfsr (
        .clk    (clk),
        .rst    (rst),
        .dither (dither_bit)
    );
`else
    assign dither_bit = 1'b0;
`endif

    assign sum_next = {1'b0, acc_reg} + {1'b0, active_reg} + {{DATA_W{1'b0}}, dither_bit};

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg <= '0;
        end else if (frame_last) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    // A boundary with a full holding register consumes it; otherwise a handshake may fill it,
    // including one landing on the boundary cycle itself (applied one frame later).
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_state_reg <= HOLD_EMPTY;
            hold_reg       <= '0;
            active_reg     <= '0;
        end else if (frameStrobe && !hold_empty) begin
            active_reg     <= hold_reg;
            hold_state_reg <= HOLD_EMPTY;
        end else if (accept) begin
            hold_reg       <= sampleIn;
            hold_state_reg <= HOLD_FULL;
        end
    end

    // The accumulator is never cleared at frame edges so the ones density stays exact.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_reg <= '0;
            dac_reg <= 1'b0;
        end else begin
            acc_reg <= sum_next[DATA_W-1:0];
            dac_reg <= sum_next[DATA_W];
        end
    end

endmodule

// File: tb/tb_sigma_delta_dac.sv
// Scoreboard bench for sigma_delta_dac: cycle model pushes expectations, monitor pops at negedge.
module tb_sigma_delta_dac;

    localparam int W           = 8;
    localparam int OSR         = 64;
    localparam int CYCLE_LIMIT = 2000;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] sampleIn = '0;
    logic         sampleValid = 1'b0;
    logic         sampleReady;
    logic         dacOut;
    logic         frameStrobe;
    logic         underrun;

    sigma_delta_dac #(.DATA_W(W), .OSR(OSR)) dut (
        .clk         (clk),
        .rst         (rst),
        .sampleIn    (sampleIn),
        .sampleValid (sampleValid),
        .sampleReady (sampleReady),
        .dacOut      (dacOut),
        .frameStrobe (frameStrobe),
        .underrun    (underrun)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic dac;
        logic ready;
        logic strobe;
        logic under;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    int             ones_acc  = 0;
    int             last_ones = 0;
    int             under_cnt = 0;
    int             frame_no  = 0;
    int             pos       = 0;
    logic [OSR-1:0] bits_acc  = '0;
    logic [OSR-1:0] last_bits = '0;

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference model: the bitstream is the carry-out of a running total of applied samples,
    // i.e. a one whenever the total crosses another multiple of 2^W.
    initial begin
        int     m_pos;
        bit     m_full;
        int     m_hold;
        int     m_active;
        longint m_total;
        longint prev_total;
        bit     m_dac;
        exp_t   e;
        m_pos = 0; m_full = 0; m_hold = 0; m_active = 0; m_total = 0; m_dac = 0;
        forever begin
            @(posedge clk);
            if (rst) begin
                m_pos = 0; m_full = 0; m_active = 0; m_total = 0; m_dac = 0;
            end else begin
                prev_total = m_total;
                m_total    = m_total + m_active;
                m_dac      = (m_total >> W) != (prev_total >> W);
                if (m_pos == OSR - 1 && m_full) begin
                    m_active = m_hold;
                    m_full   = 0;
                end else if (sampleValid && !m_full) begin
                    m_hold = int'(sampleIn);
                    m_full = 1;
                end
                m_pos = (m_pos + 1) % OSR;
            end
            #2;
            e.dac    = m_dac;
            e.ready  = !m_full && !rst;
            e.strobe = (m_pos == OSR - 1) && !rst;
            e.under  = (m_pos == OSR - 1) && !rst && !m_full;
            exp_q.push_back(e);
        end
    end

    // Monitor: compares every cycle and gathers per-frame ones counts and bit patterns.
    initial begin
        exp_t e;
        @(posedge clk);
        forever begin
            @(negedge clk);
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL scoreboard: no expected entry, got dacOut=%0b", dacOut);
            end else begin
                e = exp_q.pop_front();
                check("dacOut", dacOut, e.dac);
                check("sampleReady", sampleReady, e.ready);
                check("frameStrobe", frameStrobe, e.strobe);
                check("underrun", underrun, e.under);
            end
            under_cnt += int'(underrun);
            if (rst) begin
                ones_acc = 0;
                pos      = 0;
                bits_acc = '0;
            end else begin
                bits_acc[pos] = dacOut;
                ones_acc += int'(dacOut);
                if (frameStrobe) begin
                    last_ones = ones_acc;
                    last_bits = bits_acc;
                    $display("frame %0d: ones=%0d underrun=%0b", frame_no, ones_acc, underrun);
                    frame_no++;
                    ones_acc = 0;
                    pos      = 0;
                    bits_acc = '0;
                end else if (pos < OSR - 1) begin
                    pos++;
                end
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_strobe(input string tag);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frameStrobe && n < CYCLE_LIMIT);
        if (!frameStrobe) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: no frameStrobe within %0d cycles", tag, CYCLE_LIMIT);
        end
    endtask

    initial begin
        int n;
        int u0;
        bit prev_strobe;

        // Reset state
        rst = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("reset_ready", sampleReady, 0);
        check("reset_dac", dacOut, 0);
        check("reset_strobe", frameStrobe, 0);
        check("reset_underrun", underrun, 0);

        // 64 from reset: applied from frame 1, one-cycle output latency
        rst = 1'b0; sampleValid = 1'b1; sampleIn = 8'd64;
        #1;
        check("ready_after_reset", sampleReady, 1);
        wait_strobe("f0"); next_cycle();
        check("ones_frame0", last_ones, 0);
        wait_strobe("f1"); next_cycle();
        check("ones_64_first", last_ones, 15);
        check("bits_64_first", last_bits, 64'h1111_1111_1111_1110);
        wait_strobe("f2"); next_cycle();
        check("ones_64", last_ones, 16);
        check("bits_64", last_bits, 64'h1111_1111_1111_1111);

        // 128: alternating bits, 32 ones per frame
        sampleIn = 8'd128;
        repeat (3) wait_strobe("f128");
        next_cycle();
        check("ones_128", last_ones, 32);
        check("bits_128", last_bits, 64'h5555_5555_5555_5555);
        check("no_underrun_streaming", under_cnt, 0);

        // Skip one frame of samples: one underrun, old value keeps modulating
        sampleValid = 1'b0;
        u0 = under_cnt;
        wait_strobe("f_under");
        check("underrun_pulse", underrun, 1);
        next_cycle();
        sampleValid = 1'b1;
        wait_strobe("f_after_under"); next_cycle();
        check("ones_after_underrun", last_ones, 32);
        check("underrun_count", under_cnt - u0, 1);

        // Zero: silent output, no underruns while streaming
        sampleIn = 8'd0;
        u0 = under_cnt;
        repeat (3) wait_strobe("f0a");
        next_cycle();
        check("bits_zero_a", last_bits, 64'h0);
        wait_strobe("f0b"); next_cycle();
        check("bits_zero_b", last_bits, 64'h0);
        check("no_underrun_zero", under_cnt - u0, 0);

        // Back-to-back samples with valid held high
        sampleIn = 8'h30;
        n = 0;
        do begin @(negedge clk); n++; end while (!sampleReady && n < CYCLE_LIMIT);
        check("b2b_first_accept", sampleReady, 1);
        next_cycle();
        sampleIn = 8'hD0;
        n = 0; prev_strobe = 0;
        forever begin
            @(negedge clk);
            n++;
            if (sampleReady || n >= CYCLE_LIMIT) break;
            prev_strobe = frameStrobe;
        end
        check("b2b_ready_after_strobe", prev_strobe, 1);
        check("b2b_wait_cycles", n, 64);
        next_cycle();
        sampleValid = 1'b0;

        // Reset at counter 30 with the holding register full
        repeat (29) next_cycle();
        check("hold_full_pre_reset", sampleReady, 0);
        rst = 1'b1;
        repeat (2) next_cycle();
        check("midrst_ready", sampleReady, 0);
        check("midrst_dac", dacOut, 0);
        check("midrst_strobe", frameStrobe, 0);
        check("midrst_underrun", underrun, 0);
        rst = 1'b0;
        #1;
        check("hold_discarded", sampleReady, 1);
        n = 0;
        do begin @(negedge clk); n++; end while (!frameStrobe && n < CYCLE_LIMIT);
        check("strobe_after_reset", n, 64);
        next_cycle();
        check("ones_after_reset", last_ones, 0);

        // Randomized traffic with sparse offers and rare resets
        for (int i = 0; i < 1500; i++) begin
            sampleValid = ($urandom_range(0, 63) == 0);
            sampleIn    = W'($urandom);
            rst         = ($urandom_range(0, 399) == 0);
            next_cycle();
        end
        rst = 1'b0;
        sampleValid = 1'b0;
        repeat (3) @(negedge clk);
        #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
